if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RISC-V pipeline.
- Owns the PC, issues req/ack fetches to instruction memory, and holds the IF/ID pipeline register.
- Decodes opcode/func3/func7b5 from IF/ID for the downstream control unit.
- Handles hazard stalls and taken-branch redirects (flush plus kill of an in-flight fetch).

Parameters:
- XLEN, 32: PC/address and instruction width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0) loaded into IF/ID on flush or bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1.
- imem_ack  in  1  one-cycle response strobe; ignored when imem_req=0.
- imem_rdata  in  XLEN  instruction; valid only with imem_ack.
- stall  in  1  hazard unit: hold the IF/ID register.
- branch_taken  in  1  one-cycle redirect pulse from EX.
- branch_target  in  XLEN  redirect address; bits [1:0] forced to 0.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  XLEN  PC of the IF/ID instruction.
- if_id_instr  out  XLEN  IF/ID instruction.
- opcode  out  7  if_id_instr[6:0], combinational.
- func3  out  3  if_id_instr[14:12], combinational.
- func7b5  out  1  if_id_instr[30], combinational.

Behaviour:
- Reset is synchronous, active-low, on clk; it overrides everything.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, kill=0, skid empty.
- Reset mid-fetch abandons the request; a later stray ack is ignored because req=0.
- States:
  - IDLE: one cycle after reset release, req=0 -> FETCH.
  - FETCH: req=1, addr=pc.
  - HOLD: instruction in skid, req=0.
  - DRAIN: req=1 on the old address, waiting for a killed ack.
- imem_ack may arrive in any cycle with req=1, including the first. Minimum fetch latency is 1 cycle (ack same cycle), so throughput is 1 instr/cycle.
- FETCH, ack=1, stall=0: IF/ID<=(1, pc, rdata); pc<=pc+4; stay FETCH.
- FETCH, ack=1, stall=1: skid<=(pc, rdata); pc<=pc+4; IF/ID unchanged; ->HOLD.
- FETCH, ack=0, stall=0: IF/ID<=(0, pc, NOP_INSTR) (bubble); keep requesting.
- FETCH, ack=0, stall=1: IF/ID unchanged; keep requesting.
- HOLD, stall=0: IF/ID<=skid, valid=1; ->FETCH at pc.
- HOLD, stall=1: remain in HOLD.
- branch_taken has priority over stall and ack in every state:
  - IF/ID<=(0, 0, NOP_INSTR).
  - pc<=branch_target & ~3.
  - Skid is discarded.
- Redirect in FETCH with ack=0: ->DRAIN. Request stays on the old address until ack; that data is discarded; then ->FETCH at the target.
- Redirect in FETCH with ack=1: data discarded; next cycle FETCH at the target.
- Redirect in HOLD or IDLE: ->FETCH at the target.
- Redirect in DRAIN: pc is updated to the new target; DRAIN continues.
- In DRAIN, IF/ID shows a bubble unless stall=1.
- pc+4 wraps modulo 2^XLEN with no flag.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_bubble_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on each accepted non-killed ack.
  - perf_bubble_cnt increments each cycle IF/ID loads a bubble or flush.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then ack every cycle with rdata=0x00500093 -> imem_addr sequence 0,4,8; if_id_valid=1 from cycle 3; opcode=0x13, func3=0.
- stall=1 for 3 cycles while ack arrives for addr 0x8 with 0x40208133 -> if_id_instr unchanged during stall. After release, IF/ID=(0x8, 0x40208133), func7b5=1; next fetch addr 0xC.
- Ack latency 3 cycles -> imem_addr stable through wait; two bubbles (valid=0, NOP) inserted per instruction.
- branch_taken with target 0x40 while fetch of 0x10 is outstanding -> DRAIN. The 0x10 ack data never reaches IF/ID; next req addr=0x40; IF/ID flushed to NOP.
- branch_taken with stall=1 in the same cycle -> flush wins: if_id_valid=0, pc=0x40. Target 0x43 -> fetch addr 0x40.
- rst_n=0 mid-fetch with ack the following cycle -> ack ignored; req=0 one cycle, then fetch at RESET_PC. With IF_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RISC-V instruction fetch stage: PC, imem req/ack fetch, IF/ID register, decode taps
// Optional IF_PERF_CNT_EN adds saturating fetch/bubble performance counters.
module if_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_instr,
   output logic [6:0]      opcode,
   output logic [2:0]      func3,
   output logic            func7b5
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_bubble_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] skid_pc;
   logic [XLEN-1:0] skid_instr;

   assign pc_inc = pc + XLEN'(4);
   assign tgt    = branch_target & ~XLEN'(3);

   assign opcode  = if_id_instr[6:0];
   assign func3   = if_id_instr[14:12];
   assign func7b5 = if_id_instr[30];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
         skid_pc     <= '0;
         skid_instr  <= NOP_INSTR;
      end else if (branch_taken) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
         pc          <= tgt;
         // An un-acked request cannot be withdrawn: hold it and drop its data in DRAIN.
         if ((state == FETCH || state == DRAIN) && !imem_ack) begin
            state <= DRAIN;
         end else begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= tgt;
         end
      end else begin
         case (state)
            IDLE: begin
               state     <= FETCH;
               imem_req  <= 1'b1;
               imem_addr <= pc;
            end
            FETCH: begin
               if (imem_ack) begin
                  pc        <= pc_inc;
                  imem_addr <= pc_inc;
                  if (stall) begin
                     skid_pc    <= pc;
                     skid_instr <= imem_rdata;
                     imem_req   <= 1'b0;
                     state      <= HOLD;
                  end else begin
                     if_id_valid <= 1'b1;
                     if_id_pc    <= pc;
                     if_id_instr <= imem_rdata;
                  end
               end else if (!stall) begin
                  if_id_valid <= 1'b0;
                  if_id_pc    <= pc;
                  if_id_instr <= NOP_INSTR;
               end
            end
            HOLD: begin
               if (!stall) begin
                  if_id_valid <= 1'b1;
                  if_id_pc    <= skid_pc;
                  if_id_instr <= skid_instr;
                  imem_req    <= 1'b1;
                  imem_addr   <= pc;
                  state       <= FETCH;
               end
            end
            DRAIN: begin
               if (!stall) begin
                  if_id_valid <= 1'b0;
                  if_id_pc    <= pc;
                  if_id_instr <= NOP_INSTR;
               end
               if (imem_ack) begin
                  imem_addr <= pc;
                  state     <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic fetch_hit;
   logic bubble_hit;

   assign fetch_hit  = (state == FETCH) && imem_ack && !branch_taken;
   assign bubble_hit = branch_taken
                    || ((state == FETCH) && !imem_ack && !stall)
                    || ((state == DRAIN) && !stall);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetch_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (fetch_hit && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (bubble_hit && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a latency-programmable imem responder
`timescale 1ns/1ps
module tb_if_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic        func7b5;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
`endif

   if_stage dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .opcode(opcode), .func3(func3), .func7b5(func7b5)
`ifdef IF_PERF_CNT_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          lat = 1;
   bit          ack_en = 1'b1;
   bit          force_ack = 1'b0;
   bit          kill = 1'b0;
   int          mem_wait = 0;
   int          n_acc = 0;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8) return 32'h4020_8133;
      return 32'h0050_0093 ^ (a << 20);
   endfunction

   // One clock: check IF/ID against the scoreboard, answer imem, update the model, advance.
   task automatic cycle();
      exp_t e;
      exp_t n;
      if (prev_req === 1'b1 && prev_ack === 1'b0 && imem_req === 1'b1)
         check("addr_stable", imem_addr, prev_addr);
      if (if_id_valid === 1'b0)
         check("bubble_nop", if_id_instr, NOP);
      if (if_id_valid === 1'b1 && !stall) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("if_id_pc", if_id_pc, e.pc);
            check("if_id_instr", if_id_instr, e.instr);
            check("opcode", 32'(opcode), 32'(e.instr[6:0]));
            check("func3", 32'(func3), 32'(e.instr[14:12]));
            check("func7b5", 32'(func7b5), 32'(e.instr[30]));
         end
      end
      imem_ack   = ((imem_req === 1'b1) && ack_en && (mem_wait >= lat - 1)) || force_ack;
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hdead_beef;
      if (!rst_n) begin
         exp_q.delete();
         kill  = 1'b0;
         n_acc = 0;
      end else begin
         if (branch_taken) exp_q.delete();
         if (imem_req === 1'b1 && imem_ack) begin
            if (!kill && !branch_taken) begin
               n.pc    = imem_addr;
               n.instr = imem_rdata;
               exp_q.push_back(n);
               n_acc++;
            end
            kill = 1'b0;
         end else if (imem_req === 1'b1 && branch_taken) begin
            kill = 1'b1;
         end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      mem_wait  = (imem_req === 1'b1 && !imem_ack) ? mem_wait + 1 : 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int vcyc[$];
      @(posedge clk);
      #1;
      repeat (2) cycle();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(if_id_valid), 32'd0);
      check("rst_pc", if_id_pc, 32'h0);
      check("rst_instr", if_id_instr, NOP);
`ifdef IF_PERF_CNT_EN
      check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
      check("rst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
      rst_n = 1'b1;
      check("idle_req", 32'(imem_req), 32'd0);
      cycle();
      check("c2_req", 32'(imem_req), 32'd1);
      check("c2_addr", imem_addr, 32'h0);
      check("c2_valid", 32'(if_id_valid), 32'd0);
      cycle();
      check("c3_addr", imem_addr, 32'h4);
      check("c3_valid", 32'(if_id_valid), 32'd1);
      check("c3_opcode", 32'(opcode), 32'h13);
      check("c3_func3", 32'(func3), 32'h0);
      cycle();
      check("c4_addr", imem_addr, 32'h8);
      stall = 1'b1;
      cycle();
      check("hold_req", 32'(imem_req), 32'd0);
      check("stall_instr_a", if_id_instr, mem_word(32'h4));
      cycle();
      check("stall_instr_b", if_id_instr, mem_word(32'h4));
      cycle();
      stall = 1'b0;
      cycle();
      check("skid_pc", if_id_pc, 32'h8);
      check("skid_instr", if_id_instr, 32'h4020_8133);
      check("skid_f7b5", 32'(func7b5), 32'd1);
      check("after_skid_addr", imem_addr, 32'hC);

      lat = 3;
      for (int k = 0; k < 4; k++) begin
         if (if_id_valid === 1'b1) vcyc.push_back(k);
         cycle();
      end
      check("lat3_valid_cnt", 32'(vcyc.size()), 32'd2);
      if (vcyc.size() == 2) check("lat3_bubbles", 32'(vcyc[1] - vcyc[0] - 1), 32'd2);

      check("pre_br_addr", imem_addr, 32'h10);
      check("pre_br_req", 32'(imem_req), 32'd1);
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      cycle();
      branch_taken = 1'b0;
      lat = 1;
      check("drain_addr", imem_addr, 32'h10);
      check("drain_valid", 32'(if_id_valid), 32'd0);
      cycle();
      check("redir_addr", imem_addr, 32'h40);
      check("redir_instr", if_id_instr, NOP);
      cycle();
      check("redir_if_id_pc", if_id_pc, 32'h40);

      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h43;
      cycle();
      stall        = 1'b0;
      branch_taken = 1'b0;
      check("flush_valid", 32'(if_id_valid), 32'd0);
      check("flush_pc", if_id_pc, 32'h0);
      check("flush_addr", imem_addr, 32'h40);
      cycle();
      stall = 1'b1;
      cycle();
      check("hold2_req", 32'(imem_req), 32'd0);
      branch_taken  = 1'b1;
      branch_target = 32'h80;
      cycle();
      branch_taken = 1'b0;
      stall        = 1'b0;
      check("hold_br_valid", 32'(if_id_valid), 32'd0);
      check("hold_br_addr", imem_addr, 32'h80);
      cycle();
      check("hold_br_if_id_pc", if_id_pc, 32'h80);

      lat = 3;
      cycle();
      check("mid_req", 32'(imem_req), 32'd1);
      rst_n = 1'b0;
      cycle();
      check("mrst_req", 32'(imem_req), 32'd0);
      check("mrst_valid", 32'(if_id_valid), 32'd0);
      check("mrst_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
      check("mrst_perf_fetch", perf_fetch_cnt, 32'd0);
      check("mrst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
      rst_n     = 1'b1;
      force_ack = 1'b1;
      cycle();
      force_ack = 1'b0;
      check("post_rst_req", 32'(imem_req), 32'd1);
      check("post_rst_addr", imem_addr, 32'h0);
      check("stray_ack_valid", 32'(if_id_valid), 32'd0);
      lat = 1;
      repeat (6) cycle();
      ack_en = 1'b0;
      repeat (4) cycle();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
      check("perf_fetch_end", perf_fetch_cnt, 32'(n_acc));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
